// File: rtl/lvds_rx_deser_if.sv
// Link-side bundle for the LVDS receive deserializer: DDIO bit pair in, word/status out.
// With LVDS_RX_STATS_EN defined the bundle also carries the word/error statistics counters.
interface lvds_rx_deser_if;
    logic       rx_r;
    logic       rx_f;
    logic [7:0] data_out;
    logic       data_valid;
    logic       locked;
    logic       sync_err;
`ifdef LVDS_RX_STATS_EN
    logic [15:0] word_count;
    logic [7:0]  err_count;

    modport master (
        output rx_r, rx_f,
        input  data_out, data_valid, locked, sync_err, word_count, err_count
    );

    modport slave (
        input  rx_r, rx_f,
        output data_out, data_valid, locked, sync_err, word_count, err_count
    );
`else
    modport master (
        output rx_r, rx_f,
        input  data_out, data_valid, locked, sync_err
    );

    modport slave (
        input  rx_r, rx_f,
        output data_out, data_valid, locked, sync_err
    );
`endif
endinterface

// File: rtl/lvds_rx_deser.sv
// LVDS receive deserializer: idle/sync detection, lock acquisition, 8-bit word per 5-cycle frame.
// Optional statistics counters (word_count, err_count) are built when LVDS_RX_STATS_EN is defined.
module lvds_rx_deser #(
    parameter int unsigned IDLE_MIN    = 16,
    parameter int unsigned LOCK_FRAMES = 2
) (
    input  logic           clk,
    input  logic           reset_n,
    lvds_rx_deser_if.slave link
);

    localparam logic [7:0] IDLE_MIN_C    = IDLE_MIN[7:0];
    localparam logic [3:0] LOCK_FRAMES_C = LOCK_FRAMES[3:0];

    typedef enum logic [1:0] {
        IDLE_WAIT = 2'd0,
        HUNT      = 2'd1,
        DATA      = 2'd2,
        SYNC      = 2'd3
    } state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    state_t     state;
    state_t     state_nxt;

    logic [1:0] pair;
    logic       pair_idle;
    logic       pair_sync;

    logic [7:0] idle_cnt;
    logic [7:0] idle_cnt_nxt;
    logic [7:0] idle_inc;
    logic [3:0] good_cnt;
    logic [3:0] good_cnt_nxt;
    logic [3:0] good_inc;
    logic [1:0] bit_cnt;
    logic [1:0] bit_cnt_nxt;
    logic       locked_q;
    logic       locked_nxt;

    logic [5:0] sr;
    logic [7:0] word_p0;
    logic       emit;
    logic       err;

    logic [7:0] data_p1;
    logic       vld_p1;
    logic       err_p1;

    assign pair      = {link.rx_r, link.rx_f};
    assign pair_idle = (pair == 2'b00);
    assign pair_sync = (pair == 2'b10);
    assign idle_inc  = sat_inc8(idle_cnt);
    assign good_inc  = sat_inc4(good_cnt);
    // Oldest pair lands in the top bits, so the first data cycle carries bits 7:6.
    assign word_p0   = {sr, pair};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE_WAIT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE_WAIT: begin
                if (pair_idle && (idle_inc >= IDLE_MIN_C)) begin
                    state_nxt = HUNT;
                end
            end
            HUNT: begin
                if (pair_sync) begin
                    state_nxt = DATA;
                end else if (!pair_idle) begin
                    state_nxt = IDLE_WAIT;
                end
            end
            DATA: begin
                if (bit_cnt == 2'd3) begin
                    state_nxt = SYNC;
                end
            end
            SYNC: begin
                state_nxt = pair_sync ? DATA : IDLE_WAIT;
            end
            default: state_nxt = IDLE_WAIT;
        endcase
    end

    always_comb begin
        idle_cnt_nxt = idle_cnt;
        good_cnt_nxt = good_cnt;
        bit_cnt_nxt  = bit_cnt;
        locked_nxt   = locked_q;
        emit         = 1'b0;
        err          = 1'b0;
        case (state)
            IDLE_WAIT: begin
                idle_cnt_nxt = pair_idle ? idle_inc : 8'd0;
            end
            HUNT: begin
                if (pair_sync) begin
                    good_cnt_nxt = 4'd1;
                    locked_nxt   = (LOCK_FRAMES_C <= 4'd1);
                    bit_cnt_nxt  = 2'd0;
                end else if (!pair_idle) begin
                    idle_cnt_nxt = 8'd0;
                end
            end
            DATA: begin
                bit_cnt_nxt = bit_cnt + 2'd1;
                // Words assembled before lock are dropped on the floor.
                if (bit_cnt == 2'd3) begin
                    emit = locked_q;
                end
            end
            SYNC: begin
                if (pair_sync) begin
                    good_cnt_nxt = good_inc;
                    bit_cnt_nxt  = 2'd0;
                    if (good_inc >= LOCK_FRAMES_C) begin
                        locked_nxt = 1'b1;
                    end
                end else if (pair_idle) begin
                    // Orderly stop: this zero already counts toward the next idle run.
                    locked_nxt   = 1'b0;
                    good_cnt_nxt = 4'd0;
                    idle_cnt_nxt = 8'd1;
                end else begin
                    locked_nxt   = 1'b0;
                    good_cnt_nxt = 4'd0;
                    idle_cnt_nxt = 8'd0;
                    err          = locked_q;
                end
            end
            default: begin
                idle_cnt_nxt = 8'd0;
            end
        endcase
    end

    // Stage p0 -> p1: registered word, strobe and error pulse.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            idle_cnt <= 8'd0;
            good_cnt <= 4'd0;
            bit_cnt  <= 2'd0;
            locked_q <= 1'b0;
            vld_p1   <= 1'b0;
            err_p1   <= 1'b0;
            data_p1  <= 8'd0;
        end else begin
            idle_cnt <= idle_cnt_nxt;
            good_cnt <= good_cnt_nxt;
            bit_cnt  <= bit_cnt_nxt;
            locked_q <= locked_nxt;
            vld_p1   <= emit;
            err_p1   <= err;
            if (emit) begin
                data_p1 <= word_p0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == DATA) begin
            sr <= word_p0[5:0];
        end
    end

    assign link.data_out   = data_p1;
    assign link.data_valid = vld_p1;
    assign link.locked     = locked_q;
    assign link.sync_err   = err_p1;

`ifdef LVDS_RX_STATS_EN
    logic [15:0] word_cnt;
    logic [7:0]  err_cnt;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            word_cnt <= 16'd0;
            err_cnt  <= 8'd0;
        end else begin
            if (emit) begin
                word_cnt <= word_cnt + 16'd1;
            end
            if (err) begin
                err_cnt <= sat_inc8(err_cnt);
            end
        end
    end

    assign link.word_count = word_cnt;
    assign link.err_count  = err_cnt;
`endif

endmodule

// File: tb/tb_lvds_rx_deser.sv
// Bench for lvds_rx_deser: frame-level vector table plus hand-written lock/loss/reset sequences.
module tb_lvds_rx_deser;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    lvds_rx_deser_if b1();
    lvds_rx_deser_if b2();

    lvds_rx_deser #(.IDLE_MIN(16), .LOCK_FRAMES(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .link(b1)
    );
    lvds_rx_deser #(.IDLE_MIN(16), .LOCK_FRAMES(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .link(b2)
    );

    typedef struct {
        logic [7:0] w;
        int         due;
    } exp_t;

    typedef struct {
        int              sel;
        int              idle_n;
        int              nfr;
        logic [3:0][7:0] w;
        logic [3:0]      emit;
        logic            exp_lock;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    exp_t q1[$];
    exp_t q2[$];
    logic allow1 = 1'b0;
    logic allow2 = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end
    endtask

    task automatic mon(input int sel, input logic v, input logic [7:0] d, input logic e);
        exp_t x;
        logic have;
        logic allow;
        allow = (sel == 1) ? allow1 : allow2;
        if (v) begin
            checks++;
            have = (sel == 1) ? (q1.size() > 0) : (q2.size() > 0);
            if (!have) begin
                errors++;
                $display("FAIL unexpected_valid dut%0d: got data_valid=1 data_out=%h at cycle %0d, required no strobe", sel, d, cyc);
            end else begin
                if (sel == 1) x = q1.pop_front();
                else          x = q2.pop_front();
                if (d !== x.w || cyc != x.due) begin
                    errors++;
                    $display("FAIL word dut%0d: got %h at cycle %0d, required %h at cycle %0d", sel, d, cyc, x.w, x.due);
                end
            end
        end
        if (e && !allow) begin
            checks++;
            errors++;
            $display("FAIL unexpected_sync_err dut%0d: got sync_err=1 at cycle %0d, required 0", sel, cyc);
        end
    endtask

    always @(negedge clk) begin
        mon(1, b1.data_valid, b1.data_out, b1.sync_err);
        mon(2, b2.data_valid, b2.data_out, b2.sync_err);
    end

    task automatic set_pair(input int sel, input logic [1:0] p);
        if (sel == 1) begin
            b1.rx_r = p[1];
            b1.rx_f = p[0];
        end else begin
            b2.rx_r = p[1];
            b2.rx_f = p[0];
        end
    endtask

    task automatic drive_pair(input int sel, input logic [1:0] p);
        set_pair(sel, p);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int sel, input int n);
        for (int i = 0; i < n; i++) drive_pair(sel, 2'b00);
    endtask

    task automatic drive_frame(input int sel, input logic [7:0] w, input logic push);
        exp_t x;
        drive_pair(sel, 2'b10);
        for (int i = 3; i >= 0; i--) drive_pair(sel, w[2*i+1 -: 2]);
        if (push) begin
            x.w   = w;
            x.due = cyc;
            if (sel == 1) q1.push_back(x);
            else          q2.push_back(x);
        end
    endtask

    task automatic rd(input int sel, output logic [7:0] d, output logic v, output logic l, output logic e);
        if (sel == 1) begin
            d = b1.data_out; v = b1.data_valid; l = b1.locked; e = b1.sync_err;
        end else begin
            d = b2.data_out; v = b2.data_valid; l = b2.locked; e = b2.sync_err;
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        set_pair(1, 2'b00);
        set_pair(2, 2'b00);
        q1.delete();
        q2.delete();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic chk_drained(input int sel, input string name);
        chk(name, (sel == 1) ? q1.size() : q2.size(), 16'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    vec_t       vecs[6];
    logic [7:0] d;
    logic       v;
    logic       l;
    logic       e;

    initial begin
        vecs[0] = '{1, 20, 2, {8'h00, 8'h00, 8'h3C, 8'hB1}, 4'b0011, 1'b1};
        vecs[1] = '{2, 16, 3, {8'h00, 8'hFF, 8'h5A, 8'hA5}, 4'b0110, 1'b1};
        vecs[2] = '{2, 10, 3, {8'h00, 8'hA5, 8'hA5, 8'hA5}, 4'b0000, 1'b0};
        vecs[3] = '{1, 16, 2, {8'h00, 8'h00, 8'h00, 8'h00}, 4'b0011, 1'b1};
        vecs[4] = '{2, 15, 3, {8'h00, 8'h12, 8'h12, 8'h12}, 4'b0000, 1'b0};
        vecs[5] = '{2, 16, 4, {8'hC3, 8'h7E, 8'h80, 8'h01}, 4'b1110, 1'b1};

        reset_n = 1'b0;
        set_pair(1, 2'b00);
        set_pair(2, 2'b00);

        for (int k = 0; k < 6; k++) begin
            do_reset();
            rd(vecs[k].sel, d, v, l, e);
            chk($sformatf("v%0d_rst_state", k), {5'd0, d, v, l, e}, 16'd0);
            idle(vecs[k].sel, vecs[k].idle_n);
            for (int f = 0; f < vecs[k].nfr; f++)
                drive_frame(vecs[k].sel, vecs[k].w[f], vecs[k].emit[f]);
            rd(vecs[k].sel, d, v, l, e);
            chk($sformatf("v%0d_locked", k), {15'd0, l}, {15'd0, vecs[k].exp_lock});
            idle(vecs[k].sel, 3);
            chk_drained(vecs[k].sel, $sformatf("v%0d_words_drained", k));
`ifdef LVDS_RX_STATS_EN
            chk($sformatf("v%0d_word_count", k),
                (vecs[k].sel == 1) ? b1.word_count : b2.word_count,
                16'($countones(vecs[k].emit)));
`endif
        end

        // Misaligned sync (11) while locked, then recovery after 16 zeros and two syncs.
        do_reset();
        idle(2, 16);
        drive_frame(2, 8'h11, 1'b0);
        drive_frame(2, 8'h22, 1'b1);
        drive_frame(2, 8'h33, 1'b1);
        allow2 = 1'b1;
        drive_pair(2, 2'b11);
        rd(2, d, v, l, e);
        chk("misalign_sync_err", {15'd0, e}, 16'd1);
        chk("misalign_unlock", {15'd0, l}, 16'd0);
        chk("misalign_no_valid", {15'd0, v}, 16'd0);
        drive_pair(2, 2'b00);
        rd(2, d, v, l, e);
        chk("misalign_err_one_cycle", {15'd0, e}, 16'd0);
        allow2 = 1'b0;
        idle(2, 15);
        drive_frame(2, 8'h44, 1'b0);
        rd(2, d, v, l, e);
        chk("relock_first_sync", {15'd0, l}, 16'd0);
        drive_frame(2, 8'h55, 1'b1);
        rd(2, d, v, l, e);
        chk("relock_second_sync", {15'd0, l}, 16'd1);
        idle(2, 3);
        chk_drained(2, "misalign_words_drained");
`ifdef LVDS_RX_STATS_EN
        chk("misalign_err_count", {8'd0, b2.err_count}, 16'd1);
        chk("misalign_word_count", b2.word_count, 16'd3);
`endif

        // Orderly stop: 00 in the sync slot counts as the first idle zero.
        do_reset();
        idle(2, 16);
        drive_frame(2, 8'h66, 1'b0);
        drive_frame(2, 8'h77, 1'b1);
        drive_pair(2, 2'b00);
        rd(2, d, v, l, e);
        chk("stop_unlock", {15'd0, l}, 16'd0);
        chk("stop_no_sync_err", {15'd0, e}, 16'd0);
        idle(2, 15);
        drive_frame(2, 8'h88, 1'b0);
        drive_frame(2, 8'h99, 1'b1);
        rd(2, d, v, l, e);
        chk("stop_relock", {15'd0, l}, 16'd1);
        idle(2, 3);
        chk_drained(2, "stop_words_drained");

        // Reset pulse in the middle of a data frame.
        do_reset();
        idle(2, 16);
        drive_frame(2, 8'hC3, 1'b0);
        drive_frame(2, 8'h3C, 1'b1);
        drive_pair(2, 2'b10);
        drive_pair(2, 2'b11);
        drive_pair(2, 2'b10);
        reset_n = 1'b0;
        drive_pair(2, 2'b00);
        reset_n = 1'b1;
        rd(2, d, v, l, e);
        chk("midreset_data_out", {8'd0, d}, 16'd0);
        chk("midreset_valid_locked_err", {13'd0, v, l, e}, 16'd0);
`ifdef LVDS_RX_STATS_EN
        chk("midreset_word_count", b2.word_count, 16'd0);
        chk("midreset_err_count", {8'd0, b2.err_count}, 16'd0);
`endif
        drive_pair(2, 2'b01);
        drive_pair(2, 2'b10);
        drive_pair(2, 2'b11);
        drive_pair(2, 2'b00);
        rd(2, d, v, l, e);
        chk("midreset_stays_unlocked", {15'd0, l}, 16'd0);
        idle(2, 3);
        chk_drained(2, "midreset_words_drained");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lvds_rx_deser.md
Name: lvds_rx_deser

Overview:
- Receive-side deserializer for the FPGA-to-FPGA LVDS link. It consumes the DDR bitstream produced by the transmit serializer.
- Link format: an idle run of zeros, then repeated 5-cycle frames. Each frame is one sync cycle (high half 1, low half 0) followed by 4 data cycles, 2 bits per cycle, MSB first.
- The block detects idle and sync, acquires lock, and emits one 8-bit word per frame to downstream logic with a valid strobe.
- It sits directly behind the DDIO input register on the receive side, clocked by the forwarded link clock.

Parameters:
- IDLE_MIN, 16: minimum consecutive all-zero cycles required before sync hunting begins (1..255).
- LOCK_FRAMES, 2: consecutive correct sync cycles required before locked asserts and words are emitted (1..15).

Ports:
- clk  input  1  forwarded link clock; all logic on posedge.
- reset_n  input  1  synchronous, active-low reset.
- rx_r  input  1  bit transmitted while clk is high (from DDIO), valid for the current cycle.
- rx_f  input  1  bit transmitted while clk is low (from DDIO), valid for the current cycle.
- data_out  output  8  last received word; held between strobes.
- data_valid  output  1  one-cycle strobe; data_out is new in this cycle.
- locked  output  1  link aligned; words are being emitted.
- sync_err  output  1  one-cycle strobe on an incorrect sync cycle while aligned.

Behaviour:
- Reset values: data_out=0, data_valid=0, locked=0, sync_err=0, state=IDLE_WAIT, idle_cnt=0, good_cnt=0. Reset asserted mid-frame aborts everything on the next edge.
- Pair p={rx_r,rx_f} is sampled each cycle.
- IDLE_WAIT:
  - p==00: idle_cnt++, saturating at 255.
  - Any other p: idle_cnt=0.
  - When idle_cnt>=IDLE_MIN and p==00: go to HUNT.
- HUNT:
  - p==00: stay.
  - p==10: good_cnt=1; if LOCK_FRAMES==1, set locked; go to DATA with bit_cnt=0.
  - p==01 or p==11: go to IDLE_WAIT, idle_cnt=0.
- DATA: shift register sr<= {sr[5:0], rx_r, rx_f}; bit_cnt++.
  - On bit_cnt==3, the shifted value is the complete word; go to SYNC.
  - If locked at that edge: data_out<=word and data_valid=1 on the following cycle. Latency is 1 cycle after the cycle carrying bits 1:0.
  - Words completed while not locked are discarded.
- SYNC:
  - p==10: good_cnt++, saturating at 15; if good_cnt reaches LOCK_FRAMES, set locked; go to DATA.
  - p==00: orderly link stop. Clear locked and good_cnt, no sync_err, go to IDLE_WAIT with idle_cnt=1.
  - p==01 or p==11: misalignment. Clear locked and good_cnt, go to IDLE_WAIT with idle_cnt=0. Pulse sync_err for one cycle only if locked was 1.
- data_valid and sync_err are never asserted in the same cycle. data_valid is 0 whenever locked was 0 at word completion.
- Maximum throughput: 1 word per 5 cycles. There is no backpressure; the downstream must accept every strobe.

Optional Feature:
- Macro: LVDS_RX_STATS_EN.
- Defined: adds output ports word_count[15:0] and err_count[7:0].
  - word_count increments on each data_valid and wraps at 0xFFFF->0.
  - err_count increments on each sync_err and saturates at 0xFF.
  - Both are cleared only by reset.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- 20 cycles of 00, then frames (10,10,11,00,01) then (10,00,11,11,00) with LOCK_FRAMES=1 -> locked after the first sync; data_valid with data_out=0x B1 (10 11 00 01 = 0xB1), then 0x3C, each 1 cycle after the last data cycle.
- Default LOCK_FRAMES=2, 16 idle cycles, 3 frames carrying 0xA5, 0x5A, 0xFF -> first word discarded, locked rises at the second sync, data_valid for 0x5A and 0xFF only.
- Only 10 idle cycles, then a frame -> stays in IDLE_WAIT/HUNT never reached; no locked, no data_valid.
- Locked stream, sync cycle replaced by 11 -> sync_err one cycle, locked=0; recovers only after ≥16 zeros plus LOCK_FRAMES syncs.
- Locked stream, sync cycle replaced by 00 followed by zeros -> locked=0, sync_err stays 0.
- reset_n low for 1 cycle in the middle of a DATA cycle -> all outputs 0 next cycle; no partial word emitted; with LVDS_RX_STATS_EN, counters read 0.
